// File: rtl/keypad_scanner_if.sv
// Keypad-side and game-side signals of the 4x4 keypad scanner.
// The scanner is the slave; the board/game side is the master.
interface keypad_scanner_if;
  logic       enable;
  logic [3:0] keycol;
  logic [3:0] keyrow;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output enable, keycol,
    input  keyrow, key_code, key_valid, key_held
  );

  modport slave (
    input  enable, keycol,
    output keyrow, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad reader: drives one row low at a time, buffers a full frame of
// column samples, then debounces the lowest-index closure into key events.
module keypad_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.slave kp_io
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  typedef enum logic {SCAN, EVAL} state_e;

  state_e           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0][3:0]  col_buf_q, col_buf_d;
  logic [3:0]       stable_cnt_q, stable_cnt_d;
  logic [4:0]       prev_snap_q, prev_snap_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       keyrow_q, keyrow_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic [4:0] snap;
  logic [3:0] cnt_new;
  logic       same_snap;
  logic       accept;

  // Walk from the highest index down so the lowest closed key overwrites last.
  always_comb begin
    snap = 5'd0;
    for (int r = 3; r >= 0; r--) begin
      for (int c = 3; c >= 0; c--) begin
        if (!col_buf_q[r][c]) begin
          snap = {1'b1, 4'(r * 4 + c)};
        end
      end
    end
  end

  always_comb begin
    same_snap = (snap == prev_snap_q);
    if (!same_snap) begin
      cnt_new = 4'd1;
    end else if (stable_cnt_q >= DEB) begin
      cnt_new = DEB;
    end else begin
      cnt_new = stable_cnt_q + 4'd1;
    end
    // A fresh arrival at the threshold, not a frame that was already saturated.
    accept = (cnt_new == DEB) && !(same_snap && stable_cnt_q == DEB);
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    div_d        = div_q;
    col_buf_d    = col_buf_q;
    stable_cnt_d = stable_cnt_q;
    prev_snap_d  = prev_snap_q;
    key_code_d   = key_code_q;
    key_held_d   = key_held_q;
    key_valid_d  = 1'b0;
    keyrow_d     = 4'b1111;

    if (!kp_io.enable) begin
      state_d      = SCAN;
      row_d        = 2'd0;
      div_d        = '0;
      stable_cnt_d = 4'd0;
      prev_snap_d  = 5'd0;
      key_held_d   = 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (div_q == DIV_LAST) begin
            col_buf_d[row_q] = sync2_q;
            div_d            = '0;
            if (row_q == 2'd3) begin
              state_d = EVAL;
              row_d   = 2'd0;
            end else begin
              row_d = row_q + 2'd1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        EVAL: begin
          state_d      = SCAN;
          row_d        = 2'd0;
          stable_cnt_d = cnt_new;
          prev_snap_d  = snap;
          if (accept) begin
            if (snap[4]) begin
              if (!key_held_q || snap[3:0] != key_code_q) begin
                key_code_d  = snap[3:0];
                key_held_d  = 1'b1;
                key_valid_d = 1'b1;
              end
            end else begin
              key_held_d = 1'b0;
            end
          end
        end
      endcase

      if (state_d == SCAN) begin
        keyrow_d = ~(4'b0001 << row_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SCAN;
      row_q        <= 2'd0;
      div_q        <= '0;
      col_buf_q    <= {4{4'b1111}};
      stable_cnt_q <= 4'd0;
      prev_snap_q  <= 5'd0;
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      keyrow_q     <= 4'b1111;
      key_code_q   <= 4'd0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      div_q        <= div_d;
      col_buf_q    <= col_buf_d;
      stable_cnt_q <= stable_cnt_d;
      prev_snap_q  <= prev_snap_d;
      sync1_q      <= kp_io.keycol;
      sync2_q      <= sync1_q;
      keyrow_q     <= keyrow_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
    end
  end

  assign kp_io.keyrow    = keyrow_q;
  assign kp_io.key_code  = key_code_q;
  assign kp_io.key_valid = key_valid_q;
  assign kp_io.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model answers the row drive,
// expected key events are queued by the stimulus and checked by a monitor.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  typedef struct {
    logic [3:0] code;
    int         frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = 16'd0;
  logic [3:0]  last_row = 4'b1111;
  int          n_checks = 0;
  int          n_fail = 0;
  int          eval_cnt = 0;
  exp_t        exp_q[$];
  exp_t        e;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
    .clk   (clk),
    .rst   (rst),
    .kp_io (kp)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a closed key pulls its column low while its row is driven.
  function automatic logic [3:0] col_model(input logic [3:0] rows, input logic [15:0] keys);
    logic [3:0] col;
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[r * 4 + c]) col[c] = 1'b0;
    return col;
  endfunction

  assign kp.keycol = col_model(kp.keyrow, pressed);

  // Completed frames: a 1111 cycle right after row 3 was driven is the EVAL cycle.
  always @(posedge clk) begin
    if (kp.keyrow == 4'b1111 && last_row == 4'b0111) eval_cnt <= eval_cnt + 1;
    last_row <= kp.keyrow;
  end

  always @(negedge clk) begin
    if (kp.key_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: key_code=%0d at frame %0d, required no pulse",
                 kp.key_code, eval_cnt);
      end else begin
        e = exp_q.pop_front();
        if (kp.key_code !== e.code || eval_cnt != e.frame) begin
          n_fail++;
          $display("FAIL key_pulse: key_code=%0d frame=%0d, required key_code=%0d frame=%0d",
                   kp.key_code, eval_cnt, e.code, e.frame);
        end else begin
          $display("pulse ok: key_code=%0d frame=%0d", kp.key_code, eval_cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check ok: %s = %0h", name, act);
    end
  endtask

  task automatic push_exp(input logic [3:0] code, input int frames_ahead);
    exp_t x;
    x.code  = code;
    x.frame = eval_cnt + frames_ahead;
    exp_q.push_back(x);
  endtask

  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = eval_cnt + n;
    budget = n * (4 * SCAN_DIV + 1) + 40;
    while (eval_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (eval_cnt < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout: reached frame %0d, required %0d", eval_cnt, target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_row;
    kp.enable = 1'b0;
    #12;
    check("rst_keyrow", kp.keyrow, 4'b1111);
    check("rst_key_code", kp.key_code, 4'd0);
    check("rst_key_valid", kp.key_valid, 1'b0);
    check("rst_key_held", kp.key_held, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    kp.enable = 1'b1;

    // Idle frame: row walk then one EVAL cycle
    wait_frames(1);
    for (int i = 0; i < 4 * SCAN_DIV + 1; i++) begin
      if (i < 4 * SCAN_DIV) exp_row = ~(4'b0001 << (i / SCAN_DIV));
      else exp_row = 4'b1111;
      check("idle_keyrow", kp.keyrow, exp_row);
      @(negedge clk);
    end

    // Key 9 pressed, held 10 frames, released, re-pressed
    wait_frames(1);
    pressed = 16'd1 << 9;
    push_exp(4'd9, 3);
    wait_frames(3);
    check("k9_held", kp.key_held, 1'b1);
    check("k9_code", kp.key_code, 4'd9);
    wait_frames(7);
    pressed = 16'd0;
    wait_frames(2);
    check("k9_held_2none", kp.key_held, 1'b1);
    wait_frames(1);
    check("k9_released", kp.key_held, 1'b0);
    check("k9_code_kept", kp.key_code, 4'd9);
    wait_frames(1);
    pressed = 16'd1 << 9;
    push_exp(4'd9, 3);
    wait_frames(3);
    check("k9_repress_held", kp.key_held, 1'b1);
    pressed = 16'd0;
    wait_frames(4);
    check("k9_release2", kp.key_held, 1'b0);

    // Bouncing key 5: present 1,3, absent 2,4, stable from 5
    push_exp(4'd5, 7);
    pressed = 16'd1 << 5;
    wait_frames(1);
    pressed = 16'd0;
    wait_frames(1);
    pressed = 16'd1 << 5;
    wait_frames(1);
    pressed = 16'd0;
    wait_frames(1);
    pressed = 16'd1 << 5;
    wait_frames(2);
    check("k5_not_yet", kp.key_held, 1'b0);
    wait_frames(1);
    check("k5_code", kp.key_code, 4'd5);
    pressed = 16'd0;
    wait_frames(4);

    // Keys 6 and 13 together, then release 6 only
    pressed = (16'd1 << 6) | (16'd1 << 13);
    push_exp(4'd6, 3);
    wait_frames(5);
    check("k6_code", kp.key_code, 4'd6);
    pressed = 16'd1 << 13;
    push_exp(4'd13, 3);
    wait_frames(4);
    check("k13_code", kp.key_code, 4'd13);
    check("k13_held", kp.key_held, 1'b1);

    // enable dropped mid-row while 13 is held
    repeat (6) @(negedge clk);
    kp.enable = 1'b0;
    @(negedge clk);
    check("dis_keyrow", kp.keyrow, 4'b1111);
    check("dis_held", kp.key_held, 1'b0);
    check("dis_code", kp.key_code, 4'd13);
    repeat (10) @(negedge clk);
    check("dis_keyrow_idle", kp.keyrow, 4'b1111);
    kp.enable = 1'b1;
    push_exp(4'd13, 3);
    wait_frames(4);
    check("reen_held", kp.key_held, 1'b1);

    // Asynchronous reset mid-frame while held
    repeat (20) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_keyrow", kp.keyrow, 4'b1111);
    check("arst_code", kp.key_code, 4'd0);
    check("arst_held", kp.key_held, 1'b0);
    check("arst_valid", kp.key_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    push_exp(4'd13, 3);
    wait_frames(4);
    check("post_rst_code", kp.key_code, 4'd13);
    pressed = 16'd0;
    wait_frames(4);
    check("final_held", kp.key_held, 1'b0);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
